// File: rtl/sprite_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : sprite_frame_reader
// Description : Latches animation frame selection once per video frame and
//               turns scan positions into sprite-sheet ROM reads with
//               horizontal mirroring, returning colour plus opacity.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_frame_reader #(
  parameter int                 CELL_W      = 48,
  parameter int                 CELL_H      = 48,
  parameter int                 SHEET_COLS  = 16,
  parameter int                 SHEET_ROWS  = 8,
  parameter int                 ADDR_W      = 19,
  parameter int                 COLOR_W     = 6,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 6'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [10:0]        anim_row,
  input  logic [10:0]        anim_col,
  input  logic [5:0]         max_width,
  input  logic               facing_left,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic [9:0]         scan_x,
  input  logic [9:0]         scan_y,
  input  logic               pix_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               pix_valid,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_opaque,
  output logic               frame_err
);

  localparam int c_WID_W = $clog2(CELL_W + 1);
  localparam int c_ROW_W = $clog2(SHEET_ROWS);
  localparam int c_COL_W = $clog2(SHEET_COLS);

  // Shadow copy of the frame selection, stable for a whole video frame
  logic [c_ROW_W-1:0] r_row;
  logic [c_COL_W-1:0] r_col;
  logic [c_WID_W-1:0] r_width;
  logic               r_facing;
  logic [9:0]         r_sx;
  logic [9:0]         r_sy;

  logic               r_hit_d1;
  logic               r_req_d1;

  logic               w_range_bad;
  logic [c_WID_W-1:0] w_width_in;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic               w_hit;
  logic [31:0]        w_lx;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_opaque;

  always_comb begin
    w_range_bad = (int'(anim_row) >= SHEET_ROWS) || (int'(anim_col) >= SHEET_COLS);
    w_width_in  = ((max_width == 6'd0) || (int'(max_width) > CELL_W))
                ? c_WID_W'(CELL_W) : c_WID_W'(max_width);

    w_dx  = signed'({1'b0, scan_x}) - signed'({1'b0, r_sx});
    w_dy  = signed'({1'b0, scan_y}) - signed'({1'b0, r_sy});
    w_hit = pix_req
         && !w_dx[10] && (int'(w_dx) < int'(r_width))
         && !w_dy[10] && (int'(w_dy) < CELL_H);

    // Only meaningful when w_hit is set, so dx is known to lie in [0, width)
    w_lx = r_facing ? (32'(r_width) - 32'd1 - 32'(w_dx[9:0])) : 32'(w_dx[9:0]);

    w_addr = ADDR_W'((32'(r_row) * 32'(CELL_H) + 32'(w_dy[9:0])) * 32'(SHEET_COLS * CELL_W)
                     + 32'(r_col) * 32'(CELL_W) + w_lx);

    w_opaque = r_hit_d1 && (rom_data != TRANSPARENT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_width   <= c_WID_W'(CELL_W);
      r_facing  <= 1'b0;
      r_sx      <= '0;
      r_sy      <= '0;
      frame_err <= 1'b0;
    end else if (frame_start) begin
      r_width  <= w_width_in;
      r_facing <= facing_left;
      r_sx     <= sprite_x;
      r_sy     <= sprite_y;
      if (w_range_bad) begin
        frame_err <= 1'b1;
      end else begin
        r_row <= anim_row[c_ROW_W-1:0];
        r_col <= anim_col[c_COL_W-1:0];
      end
    end
  end

  // Two-stage pixel pipeline: address issue, then ROM data qualification
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr   <= '0;
      r_hit_d1   <= 1'b0;
      r_req_d1   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_opaque <= 1'b0;
      pix_color  <= '0;
    end else begin
      rom_addr   <= w_hit ? w_addr : '0;
      r_hit_d1   <= w_hit;
      r_req_d1   <= pix_req;
      pix_valid  <= r_req_d1;
      pix_opaque <= w_opaque;
      pix_color  <= w_opaque ? rom_data : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_frame_reader
// Description : Directed self-checking bench for sprite_frame_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_frame_reader;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [10:0] anim_row;
  logic [10:0] anim_col;
  logic [5:0]  max_width;
  logic        facing_left;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [9:0]  scan_x;
  logic [9:0]  scan_y;
  logic        pix_req;
  logic [18:0] rom_addr;
  logic [5:0]  rom_data;
  logic        pix_valid;
  logic [5:0]  pix_color;
  logic        pix_opaque;
  logic        frame_err;

  logic        force_t;
  int          n_tests;
  int          n_fail;
  int          pulses;

  sprite_frame_reader dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .anim_row    (anim_row),
    .anim_col    (anim_col),
    .max_width   (max_width),
    .facing_left (facing_left),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .pix_req     (pix_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .pix_opaque  (pix_opaque),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rom_addr is already registered, so this models the ROM's 1-cycle read
  always_comb rom_data = force_t ? 6'h00 : (rom_addr[5:0] ^ 6'h2A);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; pulses = 0; force_t = 1'b0;
    reset = 1'b1; frame_start = 1'b0; pix_req = 1'b0;
    anim_row = '0; anim_col = '0; max_width = '0; facing_left = 1'b0;
    sprite_x = '0; sprite_y = '0; scan_x = '0; scan_y = '0;
    cyc(); cyc();
    check("rst_addr",   32'(rom_addr),   32'd0);
    check("rst_valid",  32'(pix_valid),  32'd0);
    check("rst_color",  32'(pix_color),  32'd0);
    check("rst_opaque", 32'(pix_opaque), 32'd0);
    check("rst_err",    32'(frame_err),  32'd0);
    reset = 1'b0;

    // Frame A: row 0, col 1, width 46, at (100,50)
    frame_start = 1'b1; anim_row = 11'd0; anim_col = 11'd1; max_width = 6'd46;
    facing_left = 1'b0; sprite_x = 10'd100; sprite_y = 10'd50;
    cyc(); frame_start = 1'b0;
    pix_req = 1'b1; scan_x = 10'd100; scan_y = 10'd50;
    cyc(); check("a_addr", 32'(rom_addr), 32'd48);
    pix_req = 1'b0;
    cyc();
    check("a_valid",  32'(pix_valid),  32'd1);
    check("a_opaque", 32'(pix_opaque), 32'd1);
    check("a_color",  32'(pix_color),  32'h1A);
    cyc();
    check("idle_valid", 32'(pix_valid), 32'd0);
    check("idle_color", 32'(pix_color), 32'd0);

    // Mirrored
    frame_start = 1'b1; facing_left = 1'b1;
    cyc(); frame_start = 1'b0;
    pix_req = 1'b1; scan_x = 10'd100;
    cyc(); check("m_addr_dx0", 32'(rom_addr), 32'd93);
    scan_x = 10'd145;
    cyc(); check("m_addr_last", 32'(rom_addr), 32'd48);
    check("m_color0", 32'(pix_color), 32'h37);
    scan_x = 10'd146;
    cyc(); check("m_addr_out", 32'(rom_addr), 32'd0);
    check("m_color1", 32'(pix_color), 32'h1A);
    pix_req = 1'b0;
    cyc();
    check("m_out_valid",  32'(pix_valid),  32'd1);
    check("m_out_opaque", 32'(pix_opaque), 32'd0);
    check("m_out_color",  32'(pix_color),  32'd0);

    // Mid-frame change ignored; frame_start+pix_req uses old shadow
    anim_col = 11'd3; pix_req = 1'b1; scan_x = 10'd100;
    cyc(); check("tear_addr", 32'(rom_addr), 32'd93);
    frame_start = 1'b1; facing_left = 1'b0; scan_y = 10'd51;
    cyc(); check("fs_same_cycle", 32'(rom_addr), 32'd861);
    frame_start = 1'b0;
    cyc(); check("new_frame_addr", 32'(rom_addr), 32'd912);
    pix_req = 1'b0;
    cyc(); cyc();

    // Out-of-range column, width 0 clamps to 48
    frame_start = 1'b1; anim_col = 11'd16; max_width = 6'd0; scan_y = 10'd50;
    cyc(); frame_start = 1'b0;
    check("err_set", 32'(frame_err), 32'd1);
    pix_req = 1'b1; scan_x = 10'd147;
    cyc(); check("clamp_addr", 32'(rom_addr), 32'd191);
    scan_x = 10'd148;
    cyc(); check("clamp_out_addr", 32'(rom_addr), 32'd0);
    check("clamp_color", 32'(pix_color), 32'h15);
    scan_x = 10'd99;
    cyc(); check("left_addr", 32'(rom_addr), 32'd0);
    check("clamp_out_opaque", 32'(pix_opaque), 32'd0);
    scan_x = 10'd100; scan_y = 10'd49;
    cyc(); check("top_addr", 32'(rom_addr), 32'd0);
    check("left_opaque", 32'(pix_opaque), 32'd0);
    pix_req = 1'b0; scan_y = 10'd50;
    cyc(); check("top_opaque", 32'(pix_opaque), 32'd0);
    check("top_valid", 32'(pix_valid), 32'd1);

    // Transparent key inside box
    force_t = 1'b1; pix_req = 1'b1;
    cyc(); check("tr_addr", 32'(rom_addr), 32'd144);
    pix_req = 1'b0;
    cyc();
    check("tr_valid",  32'(pix_valid),  32'd1);
    check("tr_opaque", 32'(pix_opaque), 32'd0);
    check("tr_color",  32'(pix_color),  32'd0);
    force_t = 1'b0;
    cyc(); cyc();

    // Ten back-to-back requests
    for (int i = 0; i < 14; i++) begin
      pix_req = (i < 10);
      scan_x  = 10'(100 + i);
      cyc();
      check("st_addr", 32'(rom_addr), (i < 10) ? 32'(144 + i) : 32'd0);
      check("st_valid", 32'(pix_valid), (i >= 1 && i <= 10) ? 32'd1 : 32'd0);
      if (pix_valid) pulses++;
      if (i >= 1 && i <= 10)
        check("st_color", 32'(pix_color), 32'(((143 + i) & 63) ^ 'h2A));
    end
    check("st_pulses", 32'(pulses), 32'd10);
    check("err_sticky", 32'(frame_err), 32'd1);

    // Reset with pixels in flight
    pix_req = 1'b1; scan_x = 10'd100;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    check("rr_valid", 32'(pix_valid), 32'd0);
    check("rr_addr",  32'(rom_addr),  32'd0);
    check("rr_err",   32'(frame_err), 32'd0);
    reset = 1'b0; pix_req = 1'b0;
    cyc(); check("rr_abort", 32'(pix_valid), 32'd0);
    pix_req = 1'b1; scan_x = 10'd47; scan_y = 10'd0;
    cyc(); check("rr_width_last", 32'(rom_addr), 32'd47);
    scan_x = 10'd48;
    cyc(); check("rr_width_out", 32'(rom_addr), 32'd0);
    pix_req = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
